// File: rtl/irq_router_if.sv
// Slot interrupt, CPU acknowledge and config-write signals between the Dock and irq_router.
interface irq_router_if #(
    parameter int unsigned NUM_SLOTS = 5,
    parameter int unsigned SLOT_W    = 3
);
    logic [NUM_SLOTS-1:0] slot_irq_n;
    logic                 ack_n;
    logic                 cfg_we;
    logic [7:0]           cfg_addr;
    logic [7:0]           cfg_wdata;
    logic                 cpu_int_n;
    logic                 irq_int_active;
    logic [SLOT_W-1:0]    irq_int_slot;
    logic                 irq_vec_cycle;

    modport master (
        output slot_irq_n, ack_n, cfg_we, cfg_addr, cfg_wdata,
        input  cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle
    );

    modport slave (
        input  slot_irq_n, ack_n, cfg_we, cfg_addr, cfg_wdata,
        output cpu_int_n, irq_int_active, irq_int_slot, irq_vec_cycle
    );
endinterface

// File: rtl/irq_router.sv
// Per-slot interrupt collector/arbiter with CPU acknowledge handshake.
// Optional round-robin arbitration is compiled in with IRQ_ROUND_ROBIN_EN.
module irq_router #(
    parameter int unsigned NUM_SLOTS = 5,
    parameter int unsigned SLOT_W    = 3,
    parameter logic [7:0]  CFG_BASE  = 8'hC0
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_router_if.slave  bus
);
    localparam int unsigned N = NUM_SLOTS;

    typedef enum logic [1:0] {IDLE, ASSERT, ACK} state_t;

    state_t            state, state_next;
    logic [N-1:0]      sync1, sync2, sync_prev;
    logic [N-1:0]      mask, mode, pend, pend_next;
    logic [N-1:0]      req, fall, elig, w1c, ack_clr, slot_oh;
    logic [SLOT_W-1:0] slot, slot_next, win;
    logic              win_vld, ack_take;
    logic              sel_mask, sel_mode, sel_clr;
    logic              cpu_int_n_q, active_q, vec_q;
    logic              unused_wdata;

    assign sel_mask = bus.cfg_we && (bus.cfg_addr == CFG_BASE);
    assign sel_mode = bus.cfg_we && (bus.cfg_addr == 8'(CFG_BASE + 8'd1));
    assign sel_clr  = bus.cfg_we && (bus.cfg_addr == 8'(CFG_BASE + 8'd2));
    assign unused_wdata = ^bus.cfg_wdata;

    // Synchroniser, previous synced value for edge detection, config and pending state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            sync_prev <= '1;
            mask      <= '0;
            mode      <= '0;
            pend      <= '0;
        end else begin
            sync1     <= bus.slot_irq_n;
            sync2     <= sync1;
            sync_prev <= sync2;
            if (sel_mask) mask <= bus.cfg_wdata[N-1:0];
            if (sel_mode) mode <= bus.cfg_wdata[N-1:0];
            pend      <= pend_next;
        end
    end

    assign req      = ~sync2;
    assign fall     = sync_prev & ~sync2;
    assign slot_oh  = N'(1) << slot;
    assign ack_take = (state == ASSERT) && !bus.ack_n;
    assign w1c      = sel_clr  ? bus.cfg_wdata[N-1:0] : '0;
    assign ack_clr  = ack_take ? slot_oh : '0;

    // Edge slots: a new fall beats any clear in the same cycle; level slots follow req.
    assign pend_next = (mode & (fall | (pend & ~(w1c | ack_clr)))) | (~mode & req);
    assign elig      = pend & mask;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [SLOT_W-1:0] rr_ptr;
    logic [SLOT_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rr_ptr <= '0;
        else if (ack_take) rr_ptr <= (slot == SLOT_W'(N - 1)) ? '0 : slot + 1'b1;
    end

    // Search upward from rr_ptr, wrapping at N
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = SLOT_W'((int'(rr_ptr) + k) % int'(N));
            if (!win_vld && elig[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end
`else
    // Lowest eligible index wins
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!win_vld && elig[i]) begin
                win     = SLOT_W'(i);
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= '0;
            cpu_int_n_q <= 1'b1;
            active_q    <= 1'b0;
            vec_q       <= 1'b0;
        end else begin
            state       <= state_next;
            slot        <= slot_next;
            cpu_int_n_q <= (state_next != ASSERT);
            active_q    <= (state_next != IDLE);
            vec_q       <= (state_next == ACK);
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_next = ASSERT;
                    slot_next  = win;
                end
            end
            ASSERT: begin
                if (!bus.ack_n)               state_next = ACK;
                else if (~|(elig & slot_oh))  state_next = IDLE;
            end
            ACK: begin
                if (bus.ack_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cpu_int_n      = cpu_int_n_q;
    assign bus.irq_int_active = active_q;
    assign bus.irq_int_slot   = slot;
    assign bus.irq_vec_cycle  = vec_q;
endmodule
